// File: rtl/ext_pkg.sv
// Shared constants for the immediate-extension arbiter.
package ext_pkg;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;
    localparam logic [1:0] EXT_RSVD  = 2'b11;

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational 16->32 immediate extender (zero, sign, upper; reserved acts as zero).
module imm_ext_unit
    import ext_pkg::*;
(
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        mode,
    output logic [WORD_W-1:0] result
);

    always_comb begin
        result = {{(WORD_W - IMM_W){1'b0}}, imm};
        case (mode)
            EXT_SIGN:  result = {{(WORD_W - IMM_W){imm[IMM_W-1]}}, imm};
            EXT_UPPER: result = {imm, {(WORD_W - IMM_W){1'b0}}};
            default:   result = {{(WORD_W - IMM_W){1'b0}}, imm};
        endcase
    end

endmodule

// File: rtl/ext_arbiter.sv
// Two-requester arbiter sharing one immediate extender, with a valid/ready output register.
module ext_arbiter
    import ext_pkg::*;
#(
    parameter bit          PRIO_FIXED = 1'b0,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              REQ0,
    input  logic [IMM_W-1:0]  IMM0,
    input  logic [1:0]        MODE0,
    output logic              ACK0,
    input  logic              REQ1,
    input  logic [IMM_W-1:0]  IMM1,
    input  logic [1:0]        MODE1,
    output logic              ACK1,
    input  logic              READY,
    output logic              VALID,
    output logic [WORD_W-1:0] O,
    output logic              SRC
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] o_q, o_d;
    logic              src_q, src_d;
    logic              last_q, last_d;
    logic [3:0]        wait_q, wait_d;

    logic              slot_free;
    logic              pick1;
    logic              grant0, grant1;
    logic [IMM_W-1:0]  sel_imm;
    logic [1:0]        sel_mode;
    logic [WORD_W-1:0] ext_result;

    // On a tie, pick1 decides; last_q resets to 1 so requester 0 wins the first tie.
    always_comb begin
        slot_free = !valid_q || READY;
        pick1     = PRIO_FIXED ? (wait_q == MaxWait) : !last_q;
        grant0    = reset_n && slot_free && REQ0 && !(REQ1 && pick1);
        grant1    = reset_n && slot_free && REQ1 && !(REQ0 && !pick1);
        sel_imm   = grant1 ? IMM1 : IMM0;
        sel_mode  = grant1 ? MODE1 : MODE0;
    end

    imm_ext_unit u_ext (
        .imm    (sel_imm),
        .mode   (sel_mode),
        .result (ext_result)
    );

    always_comb begin
        valid_d = valid_q;
        o_d     = o_q;
        src_d   = src_q;
        last_d  = last_q;
        wait_d  = wait_q;

        if (grant0 || grant1) begin
            valid_d = 1'b1;
            o_d     = ext_result;
            src_d   = grant1;
            last_d  = grant1;
        end else if (READY) begin
            valid_d = 1'b0;
        end

        if (grant1 || !REQ1) begin
            wait_d = 4'd0;
        end else if (grant0 && wait_q != 4'hF) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            o_q     <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            wait_q  <= 4'd0;
        end else begin
            valid_q <= valid_d;
            o_q     <= o_d;
            src_q   <= src_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
        end
    end

    assign ACK0  = grant0;
    assign ACK1  = grant1;
    assign VALID = valid_q;
    assign O     = o_q;
    assign SRC   = src_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Directed bench: round-robin instance plus a fixed-priority instance (MAX_WAIT=2) on shared inputs.
module tb_ext_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1, ready;
    logic [15:0] imm0, imm1;
    logic [1:0]  mode0, mode1;

    logic        ack0, ack1, valid, src;
    logic [31:0] o;
    logic        f_ack0, f_ack1, f_valid, f_src;
    logic [31:0] f_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ext_arbiter #(.PRIO_FIXED(1'b0), .MAX_WAIT(4)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .REQ0(req0), .IMM0(imm0), .MODE0(mode0), .ACK0(ack0),
        .REQ1(req1), .IMM1(imm1), .MODE1(mode1), .ACK1(ack1),
        .READY(ready), .VALID(valid), .O(o), .SRC(src)
    );

    ext_arbiter #(.PRIO_FIXED(1'b1), .MAX_WAIT(2)) u_fx (
        .clk(clk), .reset_n(reset_n),
        .REQ0(req0), .IMM0(imm0), .MODE0(mode0), .ACK0(f_ack0),
        .REQ1(req1), .IMM1(imm1), .MODE1(mode1), .ACK1(f_ack1),
        .READY(ready), .VALID(f_valid), .O(f_o), .SRC(f_src)
    );

    task automatic test_reset();
        reset_n = 1'b0;
        req0 = 1'b1; imm0 = 16'h1111; mode0 = 2'b00;
        req1 = 1'b0; imm1 = 16'h0;    mode1 = 2'b00;
        ready = 1'b1;
        #3;
        tests++;
        if (valid !== 1'b0 || o !== 32'h0 || src !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid=%b o=%h src=%b, need 0/00000000/0", valid, o, src);
        end
        tests++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_ack: ack0=%b ack1=%b, need 0/0", ack0, ack1);
        end
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_sign();
        @(negedge clk);
        req0 = 1'b1; imm0 = 16'h8001; mode0 = 2'b01; ready = 1'b1;
        #1;
        tests++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            fails++;
            $display("FAIL sign_ack: ack0=%b ack1=%b, need 1/0", ack0, ack1);
        end
        @(posedge clk); #1;
        tests++;
        if (valid !== 1'b1 || o !== 32'hFFFF8001 || src !== 1'b0) begin
            fails++;
            $display("FAIL sign_out: valid=%b o=%h src=%b, need 1/ffff8001/0", valid, o, src);
        end
        @(negedge clk);
        req0 = 1'b0;
    endtask

    task automatic test_modes();
        logic [1:0]  mds [3];
        logic [15:0] ims [3];
        logic [31:0] exp [3];
        mds = '{2'b00, 2'b10, 2'b11};
        ims = '{16'h8001, 16'h8001, 16'hABCD};
        exp = '{32'h00008001, 32'h80010000, 32'h0000ABCD};
        for (int i = 0; i < 3; i++) begin
            req0 = 1'b0; req1 = 1'b1; imm1 = ims[i]; mode1 = mds[i];
            #1;
            tests++;
            if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
                fails++;
                $display("FAIL mode%0d_ack: ack1=%b ack0=%b, need 1/0", i, ack1, ack0);
            end
            @(posedge clk); #1;
            tests++;
            if (valid !== 1'b1 || o !== exp[i] || src !== 1'b1) begin
                fails++;
                $display("FAIL mode%0d_out: valid=%b o=%h src=%b, need 1/%h/1",
                         i, valid, o, src, exp[i]);
            end
            @(negedge clk);
        end
        req1 = 1'b0;
    endtask

    task automatic test_round_robin();
        logic        exp_src [4];
        logic [31:0] exp_o;
        exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
        req0 = 1'b1; imm0 = 16'h0011; mode0 = 2'b00;
        req1 = 1'b1; imm1 = 16'h0022; mode1 = 2'b01;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (ack0 !== !exp_src[i] || ack1 !== exp_src[i]) begin
                fails++;
                $display("FAIL rr%0d_ack: ack0=%b ack1=%b, need %b/%b",
                         i, ack0, ack1, !exp_src[i], exp_src[i]);
            end
            @(posedge clk); #1;
            exp_o = exp_src[i] ? 32'h00000022 : 32'h00000011;
            tests++;
            if (src !== exp_src[i] || o !== exp_o || valid !== 1'b1) begin
                fails++;
                $display("FAIL rr%0d_out: src=%b o=%h valid=%b, need %b/%h/1",
                         i, src, o, valid, exp_src[i], exp_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        // Last round-robin result is requester 1 with 32'h22, still valid.
        req1 = 1'b0;
        req0 = 1'b1; imm0 = 16'h1234; mode0 = 2'b00;
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
                fails++;
                $display("FAIL stall%0d_ack: ack0=%b ack1=%b, need 0/0", i, ack0, ack1);
            end
            @(posedge clk); #1;
            tests++;
            if (valid !== 1'b1 || o !== 32'h00000022 || src !== 1'b1) begin
                fails++;
                $display("FAIL stall%0d_hold: valid=%b o=%h src=%b, need 1/00000022/1",
                         i, valid, o, src);
            end
            @(negedge clk);
        end
        ready = 1'b1;
        #1;
        tests++;
        if (ack0 !== 1'b1) begin
            fails++;
            $display("FAIL release_ack: ack0=%b, need 1", ack0);
        end
        @(posedge clk); #1;
        tests++;
        if (valid !== 1'b1 || o !== 32'h00001234 || src !== 1'b0) begin
            fails++;
            $display("FAIL release_out: valid=%b o=%h src=%b, need 1/00001234/0", valid, o, src);
        end
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        logic exp_src [6];
        exp_src = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        req0 = 1'b1; imm0 = 16'h0001; mode0 = 2'b00;
        req1 = 1'b1; imm1 = 16'h0002; mode1 = 2'b00;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if (f_ack0 === f_ack1) begin
                fails++;
                $display("FAIL fx%0d_ack: ack0=%b ack1=%b, need exactly one", i, f_ack0, f_ack1);
            end
            @(posedge clk); #1;
            tests++;
            if (f_src !== exp_src[i] || f_valid !== 1'b1) begin
                fails++;
                $display("FAIL fx%0d_src: src=%b valid=%b, need %b/1",
                         i, f_src, f_valid, exp_src[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        // Both still requesting; result held valid.
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (valid !== 1'b0 || o !== 32'h0 || src !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state: valid=%b o=%h src=%b, need 0/00000000/0",
                     valid, o, src);
        end
        tests++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0 || f_ack0 !== 1'b0 || f_ack1 !== 1'b0) begin
            fails++;
            $display("FAIL midreset_ack: rr=%b%b fx=%b%b, need 00/00", ack0, ack1, f_ack0, f_ack1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        tests++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            fails++;
            $display("FAIL postreset_tie: ack0=%b ack1=%b, need 1/0", ack0, ack1);
        end
        @(posedge clk); #1;
        tests++;
        if (valid !== 1'b1 || src !== 1'b0 || o !== 32'h00000001) begin
            fails++;
            $display("FAIL postreset_out: valid=%b src=%b o=%h, need 1/0/00000001", valid, src, o);
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sign();
        test_modes();
        test_round_robin();
        test_backpressure();
        test_fixed_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
